// File: rtl/bitcrush_channel_scheduler.sv
// Shares one bitcrush datapath among NUM_CH channels: per-channel holding slots,
// round-robin issue, and a channel tag pipe that steers each result back home.
module bitcrush_channel_scheduler #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int LATENCY    = 1,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_sample,
  input  logic [NUM_CH*5-1:0]          ch_bit_depth,
  output logic                         crush_valid,
  output logic [DATA_WIDTH-1:0]        crush_sample,
  output logic [4:0]                   crush_bit_depth,
  input  logic [DATA_WIDTH-1:0]        crush_result,
  input  logic                         crush_result_valid,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_sample,
  output logic                         busy,
  output logic                         tag_err
);

  logic [NUM_CH-1:0]     pending_q;
  logic [NUM_CH-1:0]     pending_d;
  logic [NUM_CH-1:0]     accept;
  logic [DATA_WIDTH-1:0] slot_sample_q [NUM_CH];
  logic [4:0]            slot_depth_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] in_sample_w   [NUM_CH];
  logic [4:0]            in_depth_w    [NUM_CH];
  logic [DATA_WIDTH-1:0] out_sample_q  [NUM_CH];
  logic [NUM_CH-1:0]     out_valid_q;

  logic [CH_W-1:0]       rr_ptr_q;
  logic [CH_W-1:0]       rr_ptr_d;
  logic                  grant_valid;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W:0]         cand_sum;
  logic [CH_W-1:0]       cand_idx;

  logic                  crush_valid_q;
  logic [DATA_WIDTH-1:0] crush_sample_q;
  logic [4:0]            crush_depth_q;

  // Stage 0 travels with the issue register; stage LATENCY lines up with result_valid.
  logic [LATENCY:0]      tag_valid_q;
  logic [CH_W-1:0]       tag_idx_q [LATENCY+1];
  logic                  tag_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign in_sample_w[gi] = in_sample[gi*DATA_WIDTH +: DATA_WIDTH];
    assign in_depth_w[gi]  = ch_bit_depth[gi*5 +: 5];
    assign out_sample[gi*DATA_WIDTH +: DATA_WIDTH] = out_sample_q[gi];
  end

  assign in_ready = ~pending_q;
  assign accept   = in_valid & ~pending_q;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (cand_sum >= (CH_W+1)'(NUM_CH)) begin
        cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
      end
      cand_idx = cand_sum[CH_W-1:0];
      if (!grant_valid && pending_q[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pending_d = pending_q | accept;
    rr_ptr_d  = rr_ptr_q;
    if (grant_valid) begin
      pending_d[grant_idx] = 1'b0;
      rr_ptr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      rr_ptr_q       <= '0;
      crush_valid_q  <= 1'b0;
      crush_sample_q <= '0;
      crush_depth_q  <= '0;
      tag_valid_q    <= '0;
      out_valid_q    <= '0;
      tag_err_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        slot_sample_q[c] <= '0;
        slot_depth_q[c]  <= '0;
        out_sample_q[c]  <= '0;
      end
      for (int s = 0; s <= LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        if (accept[c]) begin
          slot_sample_q[c] <= in_sample_w[c];
          slot_depth_q[c]  <= in_depth_w[c];
        end
      end

      crush_valid_q <= grant_valid;
      if (grant_valid) begin
        crush_sample_q <= slot_sample_q[grant_idx];
        crush_depth_q  <= slot_depth_q[grant_idx];
      end

      tag_valid_q[0] <= grant_valid;
      tag_idx_q[0]   <= grant_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_valid_q[s] <= tag_valid_q[s-1];
        tag_idx_q[s]   <= tag_idx_q[s-1];
      end

      // A result with no matching tag is dropped and flagged; the datapath is lockstep.
      out_valid_q <= '0;
      if (crush_result_valid) begin
        if (tag_valid_q[LATENCY]) begin
          out_valid_q[tag_idx_q[LATENCY]]  <= 1'b1;
          out_sample_q[tag_idx_q[LATENCY]] <= crush_result;
        end else begin
          tag_err_q <= 1'b1;
        end
      end
    end
  end

  assign crush_valid     = crush_valid_q;
  assign crush_sample    = crush_sample_q;
  assign crush_bit_depth = crush_depth_q;
  assign out_valid       = out_valid_q;
  assign tag_err         = tag_err_q;
  assign busy            = (|pending_q) | (|tag_valid_q) | crush_valid_q;

  a_out_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_valid_q));
  a_grant_range: assert property (@(posedge clk) disable iff (rst)
    grant_valid |-> (int'(grant_idx) < NUM_CH));

endmodule

// File: tb/tb_bitcrush_channel_scheduler.sv
// Directed bench: two schedulers (LATENCY 1 and 3), each with a small lockstep datapath model.
module tb_bitcrush_channel_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]   in_valid1, in_ready1, out_valid1;
  logic [127:0] in_sample1, out_sample1;
  logic [19:0]  depth1;
  logic         crush_valid1, crush_result_valid1, busy1, tag_err1, spur1;
  logic [31:0]  crush_sample1, crush_result1;
  logic [4:0]   crush_depth1;

  logic [3:0]   in_valid3, in_ready3, out_valid3;
  logic [127:0] in_sample3, out_sample3;
  logic [19:0]  depth3;
  logic         crush_valid3, crush_result_valid3, busy3, tag_err3;
  logic [31:0]  crush_sample3, crush_result3;
  logic [4:0]   crush_depth3;

  bitcrush_channel_scheduler #(.NUM_CH(4), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_sample(in_sample1), .ch_bit_depth(depth1), .crush_valid(crush_valid1),
    .crush_sample(crush_sample1), .crush_bit_depth(crush_depth1),
    .crush_result(crush_result1), .crush_result_valid(crush_result_valid1),
    .out_valid(out_valid1), .out_sample(out_sample1), .busy(busy1), .tag_err(tag_err1)
  );

  bitcrush_channel_scheduler #(.NUM_CH(4), .DATA_WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_sample(in_sample3), .ch_bit_depth(depth3), .crush_valid(crush_valid3),
    .crush_sample(crush_sample3), .crush_bit_depth(crush_depth3),
    .crush_result(crush_result3), .crush_result_valid(crush_result_valid3),
    .out_valid(out_valid3), .out_sample(out_sample3), .busy(busy3), .tag_err(tag_err3)
  );

  // Datapath model: keep the top (depth+1) bits, zero the rest.
  function automatic logic [31:0] crush_ref(input logic [31:0] s, input logic [4:0] d);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << (31 - int'(d));
    return s & m;
  endfunction

  logic        dp1_vld;
  logic [31:0] dp1_res;
  always @(posedge clk) begin
    if (rst) begin
      dp1_vld <= 1'b0;
      dp1_res <= '0;
    end else begin
      dp1_vld <= crush_valid1;
      dp1_res <= crush_ref(crush_sample1, crush_depth1);
    end
  end
  assign crush_result_valid1 = dp1_vld | spur1;
  assign crush_result1       = dp1_res;

  logic        dp3_vld [3];
  logic [31:0] dp3_res [3];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        dp3_vld[i] <= 1'b0;
        dp3_res[i] <= '0;
      end
    end else begin
      dp3_vld[0] <= crush_valid3;
      dp3_res[0] <= crush_ref(crush_sample3, crush_depth3);
      for (int i = 1; i < 3; i++) begin
        dp3_vld[i] <= dp3_vld[i-1];
        dp3_res[i] <= dp3_res[i-1];
      end
    end
  end
  assign crush_result_valid3 = dp3_vld[2];
  assign crush_result3       = dp3_res[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid1 = '0; in_sample1 = '0; depth1 = '0; spur1 = 1'b0;
    in_valid3 = '0; in_sample3 = '0; depth3 = '0;
    tick();
    tick();
    rst = 1'b0;
    compared++;
    if (in_ready1 !== 4'hF) begin
      mismatched++; $display("FAIL reset_in_ready: got %h want f", in_ready1);
    end
    compared++;
    if ({crush_valid1, crush_sample1, crush_depth1} !== 38'd0) begin
      mismatched++; $display("FAIL reset_crush: got %b %h %0d want 0 0 0", crush_valid1, crush_sample1, crush_depth1);
    end
    compared++;
    if ({out_valid1, out_sample1} !== 132'd0) begin
      mismatched++; $display("FAIL reset_out: got %h %h want 0 0", out_valid1, out_sample1);
    end
    compared++;
    if ({busy1, tag_err1} !== 2'b00) begin
      mismatched++; $display("FAIL reset_busy_err: got %b%b want 00", busy1, tag_err1);
    end
    compared++;
    if ({in_ready3, busy3, tag_err3, crush_valid3} !== 7'b1111_000) begin
      mismatched++; $display("FAIL reset_dut3: got %h %b %b %b", in_ready3, busy3, tag_err3, crush_valid3);
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    in_sample1[32 +: 32] = 32'h7FFF_FFFF;
    depth1[5 +: 5] = 5'd7;
    in_valid1 = 4'b0010;
    tick();
    in_valid1 = '0;
    compared++;
    if ({in_ready1, crush_valid1} !== 5'b1101_0) begin
      mismatched++; $display("FAIL single_accept: got %h %b want d 0", in_ready1, crush_valid1);
    end
    tick();
    compared++;
    if ({crush_valid1, crush_depth1, crush_sample1} !== {1'b1, 5'd7, 32'h7FFF_FFFF}) begin
      mismatched++; $display("FAIL single_issue: got %b %0d %h want 1 7 7fffffff", crush_valid1, crush_depth1, crush_sample1);
    end
    tick();
    compared++;
    if ({crush_valid1, out_valid1} !== 5'd0) begin
      mismatched++; $display("FAIL single_gap: got %b %h want 0 0", crush_valid1, out_valid1);
    end
    tick();
    compared++;
    if (out_valid1 !== 4'b0010) begin
      mismatched++; $display("FAIL single_out_valid: got %h want 2", out_valid1);
    end
    compared++;
    if (out_sample1 !== {32'h0, 32'h0, 32'h7F00_0000, 32'h0}) begin
      mismatched++; $display("FAIL single_out_sample: got %h want 0000000000000000_7f000000_00000000", out_sample1);
    end
    $display("single: ch1 result %h", out_sample1[32 +: 32]);
    tick();
    compared++;
    if ({out_valid1, busy1} !== 5'd0) begin
      mismatched++; $display("FAIL single_idle: got %h %b want 0 0", out_valid1, busy1);
    end
  endtask

  task automatic test_all_four();
    logic [31:0] smp [4];
    logic [4:0]  dep [4];
    logic [31:0] exp_out [4];
    logic [3:0]  exp_ov;
    smp     = '{32'h1234_5678, 32'h2468_ACF0, 32'h369D_0368, 32'h48D1_59E0};
    dep     = '{5'd3, 5'd7, 5'd15, 5'd31};
    exp_out = '{32'h1000_0000, 32'h2400_0000, 32'h369D_0000, 32'h48D1_59E0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_sample1[c*32 +: 32] = smp[c];
      depth1[c*5 +: 5] = dep[c];
    end
    in_valid1 = 4'hF;
    tick();
    in_valid1 = '0;
    compared++;
    if (in_ready1 !== 4'h0) begin
      mismatched++; $display("FAIL four_accept: got %h want 0", in_ready1);
    end
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t <= 4) begin
        compared++;
        if ({crush_valid1, crush_depth1, crush_sample1} !== {1'b1, dep[t-1], smp[t-1]}) begin
          mismatched++;
          $display("FAIL four_issue%0d: got %b %0d %h want 1 %0d %h", t, crush_valid1, crush_depth1, crush_sample1, dep[t-1], smp[t-1]);
        end
        $display("four: issue depth %0d sample %h", crush_depth1, crush_sample1);
      end else begin
        compared++;
        if (crush_valid1 !== 1'b0) begin
          mismatched++; $display("FAIL four_noissue%0d: got %b want 0", t, crush_valid1);
        end
      end
      exp_ov = (t >= 3) ? 4'(1 << (t - 3)) : 4'h0;
      compared++;
      if (out_valid1 !== exp_ov) begin
        mismatched++; $display("FAIL four_out_valid%0d: got %h want %h", t, out_valid1, exp_ov);
      end
    end
    for (int c = 0; c < 4; c++) begin
      compared++;
      if (out_sample1[c*32 +: 32] !== exp_out[c]) begin
        mismatched++; $display("FAIL four_out_sample%0d: got %h want %h", c, out_sample1[c*32 +: 32], exp_out[c]);
      end
    end
  endtask

  task automatic test_fairness();
    int g0, g2;
    logic [31:0] exp_s;
    g0 = 0;
    g2 = 0;
    in_sample1[0 +: 32]  = 32'h0000_0C00;
    in_sample1[64 +: 32] = 32'h0000_0C22;
    in_valid1 = 4'b0101;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 1) begin
        compared++;
        if (crush_valid1 !== 1'b0) begin
          mismatched++; $display("FAIL fair_first: got %b want 0", crush_valid1);
        end
      end else begin
        exp_s = (i % 2 == 0) ? 32'h0000_0C00 : 32'h0000_0C22;
        compared++;
        if ({crush_valid1, crush_sample1} !== {1'b1, exp_s}) begin
          mismatched++; $display("FAIL fair_grant%0d: got %b %h want 1 %h", i, crush_valid1, crush_sample1, exp_s);
        end
      end
      if (crush_valid1 && crush_sample1 == 32'h0000_0C00) g0++;
      if (crush_valid1 && crush_sample1 == 32'h0000_0C22) g2++;
      in_valid1 = in_ready1 & 4'b0101;
    end
    in_valid1 = '0;
    compared++;
    if (g0 != 50 || g2 != 49) begin
      mismatched++; $display("FAIL fair_counts: got ch0=%0d ch2=%0d want 50 49", g0, g2);
    end
    $display("fairness: ch0 grants %0d ch2 grants %0d", g0, g2);
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_depth_latch();
    in_sample1[96 +: 32] = 32'h8000_0001;
    depth1[15 +: 5] = 5'd3;
    in_valid1 = 4'b1000;
    tick();
    in_valid1 = '0;
    depth1[15 +: 5] = 5'd31;
    tick();
    compared++;
    if ({crush_valid1, crush_depth1} !== {1'b1, 5'd3}) begin
      mismatched++; $display("FAIL latch_depth: got %b %0d want 1 3", crush_valid1, crush_depth1);
    end
    tick();
    tick();
    compared++;
    if ({out_valid1, out_sample1[96 +: 32]} !== {4'b1000, 32'h8000_0000}) begin
      mismatched++; $display("FAIL latch_result: got %h %h want 8 80000000", out_valid1, out_sample1[96 +: 32]);
    end
    $display("depth latch: ch3 result %h", out_sample1[96 +: 32]);
  endtask

  task automatic test_latency3();
    logic [4:0] exp_d;
    logic [3:0] exp_ov;
    in_sample3[64 +: 32] = 32'hCAFE_BABE; depth3[10 +: 5] = 5'd7;
    in_sample3[0 +: 32]  = 32'h0F0F_0F0F; depth3[0 +: 5]  = 5'd11;
    in_sample3[32 +: 32] = 32'hFFFF_FFFF; depth3[5 +: 5]  = 5'd0;
    in_valid3 = 4'b0100;
    for (int t = 1; t <= 8; t++) begin
      tick();
      in_valid3 = (t == 1) ? 4'b0001 : (t == 2) ? 4'b0010 : 4'b0000;
      if (t >= 2 && t <= 4) begin
        exp_d = (t == 2) ? 5'd7 : (t == 3) ? 5'd11 : 5'd0;
        compared++;
        if ({crush_valid3, crush_depth3} !== {1'b1, exp_d}) begin
          mismatched++; $display("FAIL lat3_issue%0d: got %b %0d want 1 %0d", t, crush_valid3, crush_depth3, exp_d);
        end
      end
      exp_ov = (t == 6) ? 4'b0100 : (t == 7) ? 4'b0001 : (t == 8) ? 4'b0010 : 4'b0000;
      compared++;
      if (out_valid3 !== exp_ov) begin
        mismatched++; $display("FAIL lat3_out_valid%0d: got %h want %h", t, out_valid3, exp_ov);
      end
      if (out_valid3 != 4'b0000) $display("latency3: out_valid %b", out_valid3);
    end
    compared++;
    if (out_sample3 !== {32'h0, 32'hCA00_0000, 32'h8000_0000, 32'h0F00_0000}) begin
      mismatched++; $display("FAIL lat3_out_sample: got %h want 00000000ca000000800000000f000000", out_sample3);
    end
  endtask

  task automatic test_spurious();
    compared++;
    if (busy1 !== 1'b0) begin
      mismatched++; $display("FAIL spur_idle: got busy %b want 0", busy1);
    end
    spur1 = 1'b1;
    tick();
    spur1 = 1'b0;
    compared++;
    if ({tag_err1, out_valid1} !== 5'b1_0000) begin
      mismatched++; $display("FAIL spur_flag: got %b %h want 1 0", tag_err1, out_valid1);
    end
    tick();
    compared++;
    if ({tag_err1, out_valid1} !== 5'b1_0000) begin
      mismatched++; $display("FAIL spur_sticky: got %b %h want 1 0", tag_err1, out_valid1);
    end
    $display("spurious: tag_err %b", tag_err1);
  endtask

  task automatic test_reset_mid();
    in_sample1[0 +: 32]  = 32'h1111_1111;
    in_sample1[32 +: 32] = 32'h2222_2222;
    in_valid1 = 4'b0011;
    tick();
    in_valid1 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if ({in_ready1, busy1, tag_err1} !== 6'b1111_00) begin
      mismatched++; $display("FAIL rstmid_flags: got %h %b %b want f 0 0", in_ready1, busy1, tag_err1);
    end
    compared++;
    if ({crush_valid1, crush_sample1, crush_depth1} !== 38'd0) begin
      mismatched++; $display("FAIL rstmid_crush: got %b %h %0d want 0 0 0", crush_valid1, crush_sample1, crush_depth1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if ({out_valid1, out_sample1} !== 132'd0) begin
        mismatched++; $display("FAIL rstmid_out%0d: got %h %h want 0 0", i, out_valid1, out_sample1);
      end
    end
    $display("reset mid-operation: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_depth_latch();
    test_latency3();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
